// File: rtl/pc_fetch_pkg.sv
// Shared constants, state encoding and IF/ID record for the fetch stage.
package pc_fetch_pkg;

  localparam logic [31:0] RESET_PC_DFLT   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DFLT = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DFLT    = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DFLT   = 4096;
  localparam logic [31:0] NOP             = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        adel;
  } ifid_t;

  // Limit is computed in 34 bits so a window ending at 2^32 cannot wrap to zero.
  function automatic logic addr_bad(input logic [31:0] pc,
                                    input logic [31:0] base,
                                    input logic [31:0] words);
    logic [33:0] limit;
    limit = {2'b00, base} + {words, 2'b00};
    return (pc[1:0] != 2'b00) || (pc < base) || ({2'b00, pc} >= limit);
  endfunction

endpackage

// File: rtl/pc_fetch_ifid_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a new fetch.
module ifid_reg
  import pc_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  ifid_t ifid_q;
  ifid_t ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    if (flush) begin
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP;
      ifid_d.adel  = 1'b0;
    end else if (load) begin
      ifid_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ifid_q <= '0;
    else       ifid_q <= ifid_d;
  end

  assign q = ifid_q;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the fetch PC, applies exception/eret/redirect
// and feeds the IF/ID register.
//
// state | meaning
// IDLE  | fetching sequentially, no redirect outstanding
// PEND  | redirect captured during a stall, applied when the stall releases
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DFLT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DFLT,
  parameter logic [31:0] IM_BASE    = IM_BASE_DFLT,
  parameter int unsigned IM_WORDS   = IM_WORDS_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_adel,
  output logic        redirect_pending
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  state_e      state_q, state_d;
  logic        ifid_load;
  logic        ifid_flush;
  logic        fetch_bad;
  ifid_t       ifid_in;
  ifid_t       ifid_out;

  assign fetch_bad = addr_bad(pc_q, IM_BASE, 32'(IM_WORDS));

  always_comb begin
    ifid_in.valid = 1'b1;
    ifid_in.instr = fetch_bad ? NOP : imem_rdata;
    ifid_in.pc    = pc_q;
    ifid_in.adel  = fetch_bad;
  end

  // Redirects never flush IF/ID: the instruction fetched alongside is the delay slot.
  always_comb begin
    pc_d          = pc_q;
    state_d       = state_q;
    pend_target_d = pend_target_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    if (exc_req) begin
      pc_d       = EXC_VECTOR;
      state_d    = IDLE;
      ifid_flush = 1'b1;
    end else if (eret_req) begin
      pc_d       = epc;
      state_d    = IDLE;
      ifid_flush = 1'b1;
    end else if (stall) begin
      if (redirect_valid) begin
        pend_target_d = redirect_target;
        state_d       = PEND;
      end
    end else begin
      ifid_load = 1'b1;
      state_d   = IDLE;
      if (redirect_valid)      pc_d = redirect_target;
      else if (state_q == PEND) pc_d = pend_target_q;
      else                     pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      state_q       <= IDLE;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
    end
  end

  ifid_reg u_ifid_reg (
    .clk   (clk),
    .reset (reset),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_in),
    .q     (ifid_out)
  );

  assign imem_addr        = pc_q;
  assign id_valid         = ifid_out.valid;
  assign id_instr         = ifid_out.instr;
  assign id_pc            = ifid_out.pc;
  assign id_adel          = ifid_out.adel;
  assign redirect_pending = (state_q == PEND);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed vector bench for pc_fetch: table of per-cycle stimulus with
// hand-computed post-edge outputs, plus a long-stall sequence.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, exc_req, eret_req;
  logic [31:0] redirect_target, epc, imem_rdata;
  logic [31:0] imem_addr, id_instr, id_pc;
  logic        id_valid, id_adel, redirect_pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .exc_req          (exc_req),
    .eret_req         (eret_req),
    .epc              (epc),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .id_valid         (id_valid),
    .id_instr         (id_instr),
    .id_pc            (id_pc),
    .id_adel          (id_adel),
    .redirect_pending (redirect_pending)
  );

  typedef struct {
    bit          rst, st, rv;
    logic [31:0] rt;
    bit          exc, eret;
    logic [31:0] epc, rd;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_instr, e_pc;
    bit          chk_pc, e_adel, e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit st, bit rv, logic [31:0] rt, bit exc, bit eret,
                              logic [31:0] ep, logic [31:0] rd, logic [31:0] ea, bit ev,
                              logic [31:0] ei, logic [31:0] epc_exp, bit cp, bit ad, bit pd);
    vec_t v;
    v.rst = rst; v.st = st; v.rv = rv; v.rt = rt; v.exc = exc; v.eret = eret;
    v.epc = ep; v.rd = rd; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei;
    v.e_pc = epc_exp; v.chk_pc = cp; v.e_adel = ad; v.e_pend = pd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; stall = v.st; redirect_valid = v.rv; redirect_target = v.rt;
    exc_req = v.exc; eret_req = v.eret; epc = v.epc; imem_rdata = v.rd;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0; imem_rdata = '0;

    //               rst st rv target        exc eret epc           rdata          addr          v  instr         pc            cp ad pd
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h2408_0001, 32'h0000_3000, 0, 32'h0,        32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h2408_0001, 32'h0000_3004, 1, 32'h2408_0001, 32'h3000,    1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h2408_0002, 32'h0000_3008, 1, 32'h2408_0002, 32'h3004,    1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h2408_0003, 32'h0000_300C, 1, 32'h2408_0003, 32'h3008,    1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h3100,     0, 0, 32'h0,        32'h1000_0004, 32'h0000_3100, 1, 32'h1000_0004, 32'h300C,    1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h1000_0005, 32'h0000_3104, 1, 32'h1000_0005, 32'h3100,    1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h3200,     0, 0, 32'h0,        32'h1000_0006, 32'h0000_3104, 1, 32'h1000_0005, 32'h3100,    1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h1000_0007, 32'h0000_3104, 1, 32'h1000_0005, 32'h3100,    1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h1000_0008, 32'h0000_3200, 1, 32'h1000_0008, 32'h3104,    1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h1000_0009, 32'h0000_3204, 1, 32'h1000_0009, 32'h3200,    1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h3300,     0, 0, 32'h0,        32'h1000_000A, 32'h0000_3204, 1, 32'h1000_0009, 32'h3200,    1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 32'h3400,     1, 0, 32'h0,        32'h1000_000B, 32'h0000_4180, 0, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h3010,     32'h1000_000C, 32'h0000_3010, 0, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h1000_000D, 32'h0000_3014, 1, 32'h1000_000D, 32'h3010,    1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h3600,     1, 1, 32'h3500,     32'h1000_000E, 32'h0000_4180, 0, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h3102,     0, 0, 32'h0,        32'h1000_000F, 32'h0000_3102, 1, 32'h1000_000F, 32'h4180,    1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h1000_0010, 32'h0000_3106, 1, 32'h0,        32'h3102,     1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h7000,     0, 0, 32'h0,        32'h1000_0011, 32'h0000_7000, 1, 32'h0,        32'h3106,     1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h1000_0012, 32'h0000_7004, 1, 32'h0,        32'h7000,     1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h6FFC,     0, 0, 32'h0,        32'h1000_0013, 32'h0000_6FFC, 1, 32'h0,        32'h7004,     1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h1000_0014, 32'h0000_7000, 1, 32'h1000_0014, 32'h6FFC,    1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h2FFC,     0, 0, 32'h0,        32'h1000_0015, 32'h0000_2FFC, 1, 32'h0,        32'h7000,     1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h1000_0016, 32'h0000_3000, 1, 32'h0,        32'h2FFC,     1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h3300,     0, 0, 32'h0,        32'h1000_0017, 32'h0000_3000, 1, 32'h0,        32'h2FFC,     1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 32'h3400,     0, 0, 32'h0,        32'h1000_0018, 32'h0000_3400, 1, 32'h1000_0018, 32'h3000,    1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h1000_0019, 32'h0000_3404, 1, 32'h1000_0019, 32'h3400,    1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h3500,     0, 0, 32'h0,        32'h1000_001A, 32'h0000_3404, 1, 32'h1000_0019, 32'h3400,    1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 32'h3600,     0, 0, 32'h0,        32'h1000_001B, 32'h0000_3404, 1, 32'h1000_0019, 32'h3400,    1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h1000_001C, 32'h0000_3600, 1, 32'h1000_001C, 32'h3404,    1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h3700,     0, 0, 32'h0,        32'h1000_001D, 32'h0000_3600, 1, 32'h1000_001C, 32'h3404,    1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h1000_001E, 32'h0000_3000, 0, 32'h0,        32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h1000_001F, 32'h0000_3004, 1, 32'h1000_001F, 32'h3000,    1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'h1000_0020, 32'hFFFF_FFFC, 1, 32'h1000_0020, 32'h3004,    1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h1000_0021, 32'h0000_0000, 1, 32'h0,        32'hFFFF_FFFC, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h1000_0022, 32'h0000_0004, 1, 32'h0,        32'h0,        1, 1, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk("imem_addr", i, imem_addr, vecs[i].e_addr);
      chk("id_valid", i, 32'(id_valid), 32'(vecs[i].e_valid));
      chk("id_instr", i, id_instr, vecs[i].e_instr);
      if (vecs[i].chk_pc) chk("id_pc", i, id_pc, vecs[i].e_pc);
      chk("id_adel", i, 32'(id_adel), 32'(vecs[i].e_adel));
      chk("redirect_pending", i, 32'(redirect_pending), 32'(vecs[i].e_pend));
    end

    // Long stall: PC and IF/ID hold, later redirect overwrites an earlier one,
    // release applies the last target with the held PC as delay slot.
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 32'hAAAA_0000, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("seq_pre_addr", 100, imem_addr, 32'h0000_0008);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      stall = 1'b1;
      imem_rdata = 32'hBBBB_0000 + 32'(k);
      redirect_valid = (k == 1) || (k == 4);
      redirect_target = (k == 1) ? 32'h0000_3800 : 32'h0000_3900;
      @(posedge clk); #1;
      chk("seq_hold_addr", 101 + k, imem_addr, 32'h0000_0008);
      chk("seq_hold_instr", 101 + k, id_instr, 32'h0);
      chk("seq_hold_pc", 101 + k, id_pc, 32'h0000_0004);
      chk("seq_pend", 101 + k, 32'(redirect_pending), (k >= 1) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b0; imem_rdata = 32'hCCCC_0001;
    @(posedge clk); #1;
    chk("seq_rel_addr", 110, imem_addr, 32'h0000_3900);
    chk("seq_rel_pc", 110, id_pc, 32'h0000_0008);
    chk("seq_rel_adel", 110, 32'(id_adel), 32'd1);
    chk("seq_rel_pend", 110, 32'(redirect_pending), 32'd0);
    @(negedge clk);
    imem_rdata = 32'hCCCC_0002;
    @(posedge clk); #1;
    chk("seq_next_addr", 111, imem_addr, 32'h0000_3904);
    chk("seq_next_instr", 111, id_instr, 32'hCCCC_0002);
    chk("seq_next_valid", 111, 32'(id_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
